regfile_wb_queue: RTL

- Write-back initiator that drives the write port of the 32-entry register file (clk, reset, Reg_Write, Write_Register, Write_Data).
- Buffers write-back requests from the datapath in a DEPTH-entry FIFO.
- Issues at most one register-file write per cycle, only when the write port is granted.
- Provides combinational read-after-write forwarding for two read addresses, so readers see data that is still pending in the queue.

---
 rtl/regfile_wb_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32-entry register file write port.
// Buffers write-back requests in a small FIFO, retires at most one per
// granted cycle through a registered output stage, and forwards the
// youngest pending value for two read addresses.
module regfile_wb_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid_i,
  output logic                     wb_ready_o,
  input  logic [4:0]               wb_reg_i,
  input  logic [N-1:0]             wb_data_i,
  input  logic                     drain_en_i,
  output logic                     Reg_Write_o,
  output logic [4:0]               Write_Register_o,
  output logic [N-1:0]             Write_Data_o,
  input  logic [4:0]               query_reg_1_i,
  input  logic [4:0]               query_reg_2_i,
  output logic                     hit_1_o,
  output logic                     hit_2_o,
  output logic [N-1:0]             fwd_data_1_o,
  output logic [N-1:0]             fwd_data_2_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       entry_reg  [DEPTH];
  logic [N-1:0]     entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign count_o    = count;
  assign wb_ready_o = (count < CNT_W'(DEPTH));

  // Register 0 requests complete the handshake but are dropped here.
  assign push = wb_valid_i && wb_ready_o && (wb_reg_i != 5'd0);
  assign pop  = drain_en_i && (count != '0);

  // Entry payload storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr]  <= wb_reg_i;
      entry_data[wr_ptr] <= wb_data_i;
    end
  end

  // FIFO bookkeeping: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr              <= rd_ptr + PTR_W'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr              <= wr_ptr + PTR_W'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port: strobe follows the pop, address/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
    end else begin
      Reg_Write_o <= pop;
      if (pop) begin
        Write_Register_o <= entry_reg[rd_ptr];
        Write_Data_o     <= entry_data[rd_ptr];
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins; the
  // output stage is the oldest candidate because it commits this cycle.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    hit_1_o      = 1'b0;
    hit_2_o      = 1'b0;
    fwd_data_1_o = '0;
    fwd_data_2_o = '0;
    if (query_reg_1_i != 5'd0) begin
      if (Reg_Write_o && (Write_Register_o == query_reg_1_i)) begin
        hit_1_o      = 1'b1;
        fwd_data_1_o = Write_Data_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if (entry_valid[idx] && (entry_reg[idx] == query_reg_1_i)) begin
          hit_1_o      = 1'b1;
          fwd_data_1_o = entry_data[idx];
        end
      end
    end
    if (query_reg_2_i != 5'd0) begin
      if (Reg_Write_o && (Write_Register_o == query_reg_2_i)) begin
        hit_2_o      = 1'b1;
        fwd_data_2_o = Write_Data_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if (entry_valid[idx] && (entry_reg[idx] == query_reg_2_i)) begin
          hit_2_o      = 1'b1;
          fwd_data_2_o = entry_data[idx];
        end
      end
    end
  end

endmodule
